// File: rtl/branch_resolve_unit.sv
// Decode-stage branch resolution: stalls on unresolved operands, then issues a one-cycle registered redirect.
// Optional macro BRANCH_RESOLVE_STATS_EN adds saturating resolve/taken/stall counters.
//
// state | meaning
// IDLE  | no branch pending; resolves in the same cycle when operands are ready
// WAIT  | conditional branch in ID waiting for forwardable operands
// REDIR | redirect cycle: pc_sel/flush_ifid asserted, wrong-path ID bubbled
module branch_resolve_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       br_op,
   input  logic             Eq,
   input  logic             Ne,
   input  logic             Gt,
   input  logic             Lt,
   input  logic             opnd_rdy,
   input  logic             kill,
   input  logic [WIDTH-1:0] pc_plus4,
   input  logic [WIDTH-1:0] imm,
   input  logic [WIDTH-1:0] jmp_target,
   output logic             stall_if,
   output logic             stall_id,
   output logic             id_bubble,
   output logic             pc_sel,
   output logic [WIDTH-1:0] br_target,
   output logic             flush_ifid
`ifdef BRANCH_RESOLVE_STATS_EN
   ,
   output logic [31:0]      stat_resolved,
   output logic [31:0]      stat_taken,
   output logic [31:0]      stat_stall_cycles
`endif
);

   typedef enum logic [1:0] {IDLE, WAIT, REDIR} state_t;

   state_t           state, state_nxt;
   logic             cond, hz, taken, stall, bubble, ld_target, resolve;
   logic [WIDTH-1:0] target;

   always_comb begin
      cond  = (br_op != 3'b000) && (br_op != 3'b111);
      hz    = cond && !opnd_rdy && !kill;
      taken = 1'b0;
      case (br_op)
         3'b001:  taken = Eq;
         3'b010:  taken = Ne;
         3'b011:  taken = Gt;
         3'b100:  taken = Lt;
         3'b101:  taken = Gt | Eq;
         3'b110:  taken = Lt | Eq;
         3'b111:  taken = 1'b1;
         default: taken = 1'b0;
      endcase
      target = (br_op == 3'b111) ? jmp_target : pc_plus4 + (imm << 2);
   end

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      bubble    = 1'b0;
      ld_target = 1'b0;
      resolve   = 1'b0;
      case (state)
         IDLE: begin
            if ((br_op != 3'b000) && !kill) begin
               if (hz) begin
                  state_nxt = WAIT;
                  stall     = 1'b1;
               end else begin
                  resolve = 1'b1;
                  if (taken) begin
                     ld_target = 1'b1;
                     state_nxt = REDIR;
                  end
               end
            end
         end
         WAIT: begin
            if (kill) begin
               state_nxt = IDLE;
            end else if (!opnd_rdy) begin
               stall = 1'b1;
            end else begin
               resolve   = 1'b1;
               ld_target = taken;
               state_nxt = taken ? REDIR : IDLE;
            end
         end
         REDIR: begin
            bubble    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Reset is synchronous, so the decode above may still see a stale state during the reset cycle.
      if (rst) begin
         stall     = 1'b0;
         bubble    = 1'b0;
         ld_target = 1'b0;
         resolve   = 1'b0;
         state_nxt = IDLE;
      end
   end

   assign stall_if  = stall;
   assign stall_id  = stall;
   assign id_bubble = stall | bubble;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pc_sel     <= 1'b0;
         flush_ifid <= 1'b0;
         br_target  <= '0;
      end else begin
         state      <= state_nxt;
         pc_sel     <= ld_target;
         flush_ifid <= ld_target;
         if (ld_target) br_target <= target;
      end
   end

`ifdef BRANCH_RESOLVE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_resolved     <= '0;
         stat_taken        <= '0;
         stat_stall_cycles <= '0;
      end else begin
         if (resolve && (stat_resolved != 32'hFFFF_FFFF))       stat_resolved     <= stat_resolved + 32'd1;
         if (ld_target && (stat_taken != 32'hFFFF_FFFF))        stat_taken        <= stat_taken + 32'd1;
         if (stall && (stat_stall_cycles != 32'hFFFF_FFFF))     stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed steps followed by random traffic against a behavioural model.
// Honours BRANCH_RESOLVE_STATS_EN when the design is built with the counters.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  br_op;
   logic        Eq, Ne, Gt, Lt;
   logic        opnd_rdy, kill;
   logic [31:0] pc_plus4, imm, jmp_target;
   logic        stall_if, stall_id, id_bubble, pc_sel, flush_ifid;
   logic [31:0] br_target;
`ifdef BRANCH_RESOLVE_STATS_EN
   logic [31:0] stat_resolved, stat_taken, stat_stall_cycles;
`endif

   // Operand values the comparator flags are derived from
   logic [31:0] opa, opb;

   // Reference model
   logic        m_redir;
   logic [31:0] m_target;
   logic        m_waiting;
   int unsigned m_res, m_tkn, m_stl;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_resolve_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .br_op(br_op),
      .Eq(Eq), .Ne(Ne), .Gt(Gt), .Lt(Lt),
      .opnd_rdy(opnd_rdy), .kill(kill),
      .pc_plus4(pc_plus4), .imm(imm), .jmp_target(jmp_target),
      .stall_if(stall_if), .stall_id(stall_id), .id_bubble(id_bubble),
      .pc_sel(pc_sel), .br_target(br_target), .flush_ifid(flush_ifid)
`ifdef BRANCH_RESOLVE_STATS_EN
      , .stat_resolved(stat_resolved), .stat_taken(stat_taken),
      .stat_stall_cycles(stat_stall_cycles)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
      opa = a; opb = b;
      Eq = (a == b); Ne = (a != b); Gt = (a > b); Lt = (a < b);
   endtask

   task automatic drive(input logic [2:0] op, input logic rdy, input logic k,
                        input logic [31:0] p4, input logic [31:0] im, input logic [31:0] jt);
      br_op = op; opnd_rdy = rdy; kill = k; pc_plus4 = p4; imm = im; jmp_target = jt;
   endtask

   function automatic logic ref_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'd1: return a == b;
         3'd2: return a != b;
         3'd3: return a > b;
         3'd4: return a < b;
         3'd5: return a >= b;
         3'd6: return a <= b;
         3'd7: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // One clock: check combinational outputs, advance the model at the edge, then check registered outputs.
   task automatic tick();
      logic        is_cond, active, exp_stall, exp_bub, resolved, tk;
      logic [31:0] tgt;
      is_cond   = (br_op >= 3'd1) && (br_op <= 3'd6);
      active    = (br_op != 3'd0) && !kill;
      tk        = ref_taken(br_op, opa, opb);
      tgt       = (br_op == 3'd7) ? jmp_target : pc_plus4 + imm * 32'd4;
      exp_stall = 1'b0; exp_bub = 1'b0; resolved = 1'b0;
      if (rst) begin
      end else if (m_redir) begin
         exp_bub = 1'b1;
      end else if (active && is_cond && !opnd_rdy) begin
         exp_stall = 1'b1; exp_bub = 1'b1;
      end else begin
         resolved = active;
      end
      #1;
      check("stall_if", {31'd0, stall_if}, {31'd0, exp_stall});
      check("stall_id", {31'd0, stall_id}, {31'd0, exp_stall});
      check("id_bubble", {31'd0, id_bubble}, {31'd0, exp_bub});
      @(posedge clk);
      if (rst) begin
         m_redir = 1'b0; m_target = '0; m_waiting = 1'b0;
         m_res = 0; m_tkn = 0; m_stl = 0;
      end else begin
         m_waiting = exp_stall;
         if (exp_stall && m_stl != 32'hFFFF_FFFF) m_stl++;
         if (resolved && m_res != 32'hFFFF_FFFF) m_res++;
         if (resolved && tk) begin
            m_redir = 1'b1; m_target = tgt;
            if (m_tkn != 32'hFFFF_FFFF) m_tkn++;
         end else begin
            m_redir = 1'b0;
         end
      end
      #1;
      check("pc_sel", {31'd0, pc_sel}, {31'd0, m_redir});
      check("flush_ifid", {31'd0, flush_ifid}, {31'd0, m_redir});
      check("br_target", br_target, m_target);
`ifdef BRANCH_RESOLVE_STATS_EN
      check("stat_resolved", stat_resolved, m_res);
      check("stat_taken", stat_taken, m_tkn);
      check("stat_stall_cycles", stat_stall_cycles, m_stl);
`endif
      @(negedge clk);
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] p4, im, jt;
      m_redir = 1'b0; m_target = '0; m_waiting = 1'b0;
      m_res = 0; m_tkn = 0; m_stl = 0;
      op = 3'd0; p4 = '0; im = '0; jt = '0;
      rst = 1'b1;
      set_ops(0, 0);
      drive(3'd0, 1'b0, 1'b0, 0, 0, 0);
      @(negedge clk);
      tick();
      tick();
      check("reset_pc_sel", {31'd0, pc_sel}, 32'd0);
      check("reset_br_target", br_target, 32'd0);
      rst = 1'b0;

      // BEQ taken
      set_ops(5, 5); drive(3'd1, 1'b1, 1'b0, 32'h104, 32'h3, 0);
      tick();
      check("beq_pc_sel", {31'd0, pc_sel}, 32'd1);
      check("beq_target", br_target, 32'h110);
      drive(3'd0, 1'b1, 1'b0, 0, 0, 0);
      tick();
      check("beq_pc_sel_drop", {31'd0, pc_sel}, 32'd0);

      // BNE not taken
      set_ops(7, 7); drive(3'd2, 1'b1, 1'b0, 32'h300, 32'h1, 0);
      tick();
      check("bne_no_redirect", {31'd0, pc_sel}, 32'd0);

      // BLT waits two cycles, then taken with negative offset
      set_ops(1, 2); drive(3'd4, 1'b0, 1'b0, 32'h200, 32'hFFFF_FFFE, 0);
      tick();
      tick();
      opnd_rdy = 1'b1;
      tick();
      check("blt_target", br_target, 32'h1F8);
      drive(3'd0, 1'b0, 1'b0, 0, 0, 0);
      tick();

      // J never waits
      drive(3'd7, 1'b0, 1'b0, 0, 0, 32'h0040_0000);
      tick();
      check("j_target", br_target, 32'h0040_0000);
      drive(3'd0, 1'b0, 1'b0, 0, 0, 0);
      tick();

      // BGE killed in WAIT
      set_ops(9, 3); drive(3'd5, 1'b0, 1'b0, 32'h500, 32'h10, 0);
      tick();
      kill = 1'b1;
      tick();
      check("kill_no_redirect", {31'd0, pc_sel}, 32'd0);
      drive(3'd0, 1'b0, 1'b0, 0, 0, 0);
      tick();

      // Reset during REDIR
      drive(3'd7, 1'b1, 1'b0, 0, 0, 32'h1234_5678);
      tick();
      rst = 1'b1; drive(3'd0, 1'b0, 1'b0, 0, 0, 0);
      tick();
      check("rst_redir_target", br_target, 32'h0);
      rst = 1'b0;

      // BLE wrap-around
      set_ops(4, 4); drive(3'd6, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h2, 0);
      tick();
      check("ble_wrap_target", br_target, 32'h4);
      drive(3'd0, 1'b0, 1'b0, 0, 0, 0);
      tick();

      // Random traffic; br_op and addresses held while the model says the branch is stalled.
      for (int i = 0; i < 800; i++) begin
         rst = ($urandom_range(0, 49) == 0);
         if (!m_waiting) begin
            op = 3'($urandom_range(0, 7));
            p4 = $urandom; im = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 64));
            jt = $urandom;
         end
         if ($urandom_range(0, 3) == 0) set_ops($urandom, $urandom);
         else set_ops(32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)));
         drive(op, ($urandom_range(0, 1) != 0), ($urandom_range(0, 11) == 0), p4, im, jt);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
